alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 47 ++++
 rtl/alu_rr_arb.sv | 29 ++
 rtl/alu_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared opcode, ALU select and FSM encodings for the two-requester ALU arbiter.
// Pure definitions; no timing or flow control lives here.
// The decode helper maps an opcode onto the ripple-ALU control word.
package alu_arbiter_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;

    localparam logic [1:0] ALU_S_AND = 2'b00;
    localparam logic [1:0] ALU_S_OR  = 2'b01;
    localparam logic [1:0] ALU_S_ADD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] s;
        logic       cin;
        logic       ainv;
        logic       binv;
        logic       illegal;
    } alu_ctrl_t;

    // NOR and NAND reuse AND/OR with both operands inverted (De Morgan).
    function automatic alu_ctrl_t decode_op(input logic [2:0] op);
        alu_ctrl_t c;
        c = '0;
        case (op)
            OP_AND:  c.s = ALU_S_AND;
            OP_OR:   c.s = ALU_S_OR;
            OP_ADD:  c.s = ALU_S_ADD;
            OP_SUB:  begin c.s = ALU_S_ADD; c.binv = 1'b1; c.cin = 1'b1; end
            OP_NOR:  begin c.s = ALU_S_AND; c.ainv = 1'b1; c.binv = 1'b1; end
            OP_NAND: begin c.s = ALU_S_OR;  c.ainv = 1'b1; c.binv = 1'b1; end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin grant; the last-grant pointer resets to req1 so req0 wins the first tie.
// Latency: grants are combinational from valids; pointer updates on the grant edge.
// Backpressure: no grant while en is low; a losing requester simply stays pending.
module alu_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic gnt0,
    output logic gnt1
);

    logic last;   // 1: req1 was granted most recently

    always_comb begin
        gnt0 = en & req0_valid & (~req1_valid | last);
        gnt1 = en & req1_valid & (~req0_valid | ~last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (gnt0 | gnt1) begin
            last <= gnt1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ripple ALU and returns tagged responses.
// Latency: response LAT+1 edges after the handshake cycle (1 edge for an illegal opcode).
// Backpressure: one op in flight; both readies low until the response is taken via rsp_ready.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_cout,
    output logic        rsp_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    output logic        alu_ainv,
    output logic        alu_binv,
    output logic [1:0]  alu_s,
    input  logic [31:0] alu_result,
    input  logic        alu_cout
);

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        gnt0, gnt1, accept, exec_last;
    logic [2:0]  sel_op;
    logic [31:0] sel_a, sel_b;
    alu_ctrl_t   sel_ctrl;

    // Readies are forced low during reset even though the state already reads IDLE.
    alu_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .en         ((state == ST_IDLE) && !rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    always_comb begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        accept     = gnt0 | gnt1;
        sel_op     = gnt1 ? req1_op : req0_op;
        sel_a      = gnt1 ? req1_a  : req0_a;
        sel_b      = gnt1 ? req1_b  : req0_b;
        sel_ctrl   = decode_op(sel_op);
        exec_last  = (state == ST_EXEC) && (cnt == 4'd0);
        rsp_valid  = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = sel_ctrl.illegal ? ST_DONE : ST_EXEC;
            ST_EXEC: if (cnt == 4'd0) state_nxt = ST_DONE;
            ST_DONE: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ALU drive registers load only for legal ops so an illegal request leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_s      <= '0;
            alu_cin    <= 1'b0;
            alu_ainv   <= 1'b0;
            alu_binv   <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (accept) begin
            rsp_id <= gnt1;
            if (sel_ctrl.illegal) begin
                rsp_result <= '0;
                rsp_cout   <= 1'b0;
                rsp_err    <= 1'b1;
            end else begin
                alu_a    <= sel_a;
                alu_b    <= sel_b;
                alu_s    <= sel_ctrl.s;
                alu_cin  <= sel_ctrl.cin;
                alu_ainv <= sel_ctrl.ainv;
                alu_binv <= sel_ctrl.binv;
                cnt      <= LAT_M1;
                rsp_err  <= 1'b0;
            end
        end else if (exec_last) begin
            rsp_result <= alu_result;
            rsp_cout   <= alu_cout;
        end else if (state == ST_EXEC) begin
            cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ripple ALU and a response scoreboard.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int LAT = 2;

    logic        clk, rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_err;
    logic [31:0] rsp_result;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_cin, alu_ainv, alu_binv, alu_cout;
    logic [1:0]  alu_s;

    alu_arbiter #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ainv(alu_ainv),
        .alu_binv(alu_binv), .alu_s(alu_s),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ripple ALU: optional operand inversion, then AND / OR / ADD.
    logic [31:0] ea, eb;
    logic [32:0] sum;
    always_comb begin
        ea = alu_ainv ? ~alu_a : alu_a;
        eb = alu_binv ? ~alu_b : alu_b;
        sum = {1'b0, ea} + {1'b0, eb} + {32'd0, alu_cin};
        alu_result = '0;
        alu_cout = 1'b0;
        case (alu_s)
            2'b00: alu_result = ea & eb;
            2'b01: alu_result = ea | eb;
            2'b10: begin alu_result = sum[31:0]; alu_cout = sum[32]; end
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        cout;
        logic        err;
        logic [31:0] a;
        logic [31:0] b;
        logic        legal;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   order[$];
    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;
    int   rsp_start = 0;
    logic prev_rsp_valid = 1'b0;
    logic prev_rsp_hs = 1'b0;
    logic hold0 = 1'b0;
    logic hold1 = 1'b0;

    function automatic exp_t model(logic id, logic [2:0] op, logic [31:0] a, logic [31:0] b, int acc);
        exp_t e;
        logic [32:0] w;
        e.id = id; e.a = a; e.b = b; e.acc = acc;
        e.err = 1'b0; e.legal = 1'b1; e.cout = 1'b0; e.res = '0;
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b010: begin w = {1'b0, a} + {1'b0, b}; e.res = w[31:0]; e.cout = w[32]; end
            3'b011: begin e.res = a - b; e.cout = (a >= b); end
            3'b100: e.res = ~(a | b);
            3'b101: e.res = ~(a & b);
            default: begin e.err = 1'b1; e.legal = 1'b0; end
        endcase
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(string tag);
        total++;
        bad++;
        $error("FAIL %s observed=event expected=none", tag);
    endtask

    // One clock: sample at negedge+1, score handshakes, advance one rising edge.
    task automatic cyc();
        bit   acc0, acc1;
        exp_t e;
        #1;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (prev_rsp_hs) chk("rsp_drop", 32'(rsp_valid), 32'd0);
        if (rsp_valid && !prev_rsp_valid) rsp_start = cyc_n;
        if (rsp_valid) begin
            chk("busy_rdy0", 32'(req0_ready), 32'd0);
            chk("busy_rdy1", 32'(req1_ready), 32'd0);
            if (sbq.size() == 0) begin
                fail_now("rsp_unexpected");
            end else begin
                e = sbq[0];
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                if (rsp_ready) begin
                    chk("rsp_lat", 32'(rsp_start - e.acc), e.legal ? 32'(LAT + 1) : 32'd1);
                    void'(sbq.pop_front());
                end
            end
        end else if (sbq.size() > 0 && sbq[0].legal && cyc_n > sbq[0].acc) begin
            chk("exec_alu_a", alu_a, sbq[0].a);
            chk("exec_alu_b", alu_b, sbq[0].b);
        end
        prev_rsp_hs = rsp_valid && rsp_ready;
        prev_rsp_valid = rsp_valid;
        if (acc0 && acc1) fail_now("dual_grant");
        if (acc0) begin sbq.push_back(model(1'b0, req0_op, req0_a, req0_b, cyc_n)); order.push_back(0); end
        if (acc1) begin sbq.push_back(model(1'b1, req1_op, req1_a, req1_b, cyc_n)); order.push_back(1); end
        @(posedge clk);
        cyc_n++;
        #1;
        if (acc0 && !hold0) req0_valid = 1'b0;
        if (acc1 && !hold1) req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive(int id, logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (id == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        else         begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    endtask

    // Run until k more acceptances have happened and every response has drained.
    task automatic serve(int k, string tag);
        int target;
        int n;
        target = order.size() + k;
        n = 0;
        while ((order.size() < target || sbq.size() > 0 || rsp_valid) && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) fail_now(tag);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_result"}, rsp_result, 32'd0);
        chk({tag, "_rsp_cout"}, 32'(rsp_cout), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_ctl"}, {27'd0, alu_s, alu_cin, alu_ainv, alu_binv}, 32'd0);
        chk({tag, "_rdy0"}, 32'(req0_ready), 32'd0);
        chk({tag, "_rdy1"}, 32'(req1_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b1; req1_op = '0; req1_a = '0; req1_b = '0;
        @(negedge clk); @(negedge clk);
        chk_reset_outputs("reset");
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        cyc();

        // Simultaneous requests after reset: req0 takes the tie.
        base = order.size();
        drive(0, OP_SUB, 32'd5, 32'd3);
        drive(1, OP_OR, 32'h0000_00F0, 32'h0000_000F);
        serve(2, "tie_timeout");
        chk("tie_first", 32'(order[base]), 32'd0);
        chk("tie_second", 32'(order[base + 1]), 32'd1);

        // Both held valid: grants alternate starting from req0.
        base = order.size();
        hold0 = 1'b1; hold1 = 1'b1;
        drive(0, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        drive(1, OP_NAND, 32'h1234_5678, 32'h0F0F_0F0F);
        n = 0;
        while (order.size() < base + 3 && n < 100) begin cyc(); n++; end
        if (n >= 100) fail_now("rr_timeout");
        req0_valid = 1'b0; req1_valid = 1'b0;
        hold0 = 1'b0; hold1 = 1'b0;
        serve(0, "rr_drain");
        chk("rr_g0", 32'(order[base]), 32'd0);
        chk("rr_g1", 32'(order[base + 1]), 32'd1);
        chk("rr_g2", 32'(order[base + 2]), 32'd0);

        // Single ADD with wrap and carry out.
        drive(0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
        serve(1, "add_timeout");

        // Illegal opcode: fast error response, ALU drive untouched.
        drive(1, 3'b110, 32'hDEAD_BEEF, 32'h0000_0001);
        serve(1, "ill_timeout");
        chk("ill_alu_a", alu_a, 32'hFFFF_FFFF);
        chk("ill_alu_b", alu_b, 32'd1);
        chk("ill_alu_ctl", {27'd0, alu_s, alu_cin, alu_ainv, alu_binv}, {27'd0, 2'b10, 3'b000});
        drive(0, 3'b111, 32'h5555_5555, 32'hAAAA_AAAA);
        serve(1, "ill7_timeout");

        // Arithmetic corners.
        drive(0, OP_SUB, 32'h0000_1234, 32'h0000_1234);
        serve(1, "sub_eq_timeout");
        drive(1, OP_SUB, 32'd3, 32'd5);
        serve(1, "sub_neg_timeout");
        drive(0, OP_ADD, 32'h8000_0000, 32'h8000_0000);
        serve(1, "add_ovf_timeout");

        // Consumer stall with a competing request waiting.
        rsp_ready = 1'b0;
        drive(1, OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000);
        n = 0;
        while (!rsp_valid && n < 50) begin cyc(); n++; end
        if (n >= 50) fail_now("stall_timeout");
        drive(0, OP_AND, 32'hFFFF_0000, 32'h00FF_FF00);
        for (int i = 0; i < 10; i++) cyc();
        chk("stall_pending", 32'(sbq.size()), 32'd1);
        rsp_ready = 1'b1;
        serve(1, "stall_drain");

        // Reset pulse in the middle of EXEC discards the transaction.
        drive(0, OP_ADD, 32'd7, 32'd8);
        n = 0;
        while (sbq.size() == 0 && n < 50) begin cyc(); n++; end
        if (n >= 50) fail_now("rst_acc_timeout");
        cyc();
        #1;
        rst = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        chk_reset_outputs("midrst_hold");
        req1_valid = 1'b0;
        rst = 1'b0;
        sbq.delete();
        prev_rsp_valid = 1'b0;
        prev_rsp_hs = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("post_rst_quiet", 32'(rsp_valid), 32'd0);
        end

        // Normal operation resumes, tie pointer back at its reset value.
        base = order.size();
        drive(0, OP_OR, 32'h0000_0001, 32'h0000_0002);
        drive(1, OP_ADD, 32'h0000_0010, 32'h0000_0020);
        serve(2, "post_rst_timeout");
        chk("post_rst_first", 32'(order[base]), 32'd0);
        chk("post_rst_second", 32'(order[base + 1]), 32'd1);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
